sram_port_arbiter: RTL and testbench

//   Shares the single 16-bit off-chip SRAM between the IF stage and the MEM stage.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_wait_counter.sv | 24 ++
 rtl/sram_port_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and widths for the SRAM port arbiter
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - loadable 3-bit down-counter timing one SRAM half access
module sram_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic       last
);

    logic [2:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign last = (cnt == 3'd0);

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one 16-bit SRAM between IF and MEM as 32-bit two-half accesses
// Optional ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests instead of MEM priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = SRAM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [ADDR_W-1:0]      if_addr,
    output logic [31:0]            if_rdata,
    output logic                   if_freeze,
    input  logic                   mem_rd,
    input  logic                   mem_wr,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic [31:0]            mem_wdata,
    output logic [31:0]            mem_rdata,
    output logic                   mem_freeze,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0]      SRAM_ADDR,
    output logic                   SRAM_WE_N
);

    arb_state_t             state;
    owner_t                 owner;
    logic                   op_wr;
    logic [ADDR_W-2:0]      addr_q;
    logic [31:0]            wdata_q;
    logic [SRAM_DATA_W-1:0] lo_q;
    logic                   mem_req;
    logic                   grant;
    logic                   pick_mem;
    logic [ADDR_W-2:0]      sel_addr;
    logic                   half_last;
    logic                   cnt_load;
    logic                   drive_en;
    logic [SRAM_DATA_W-1:0] half_data;
    logic                   addr_lsb_unused;

    assign mem_req  = mem_rd | mem_wr;
    assign grant    = if_req | mem_req;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_grant;

    // On a tie the requester that did not win last time gets the SRAM.
    assign pick_mem = mem_req && (!if_req || last_grant == OWN_IF);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_IF;
        end else if (state == IDLE && grant) begin
            last_grant <= pick_mem ? OWN_MEM : OWN_IF;
        end
    end
`else
    assign pick_mem = mem_req;
`endif

    // Halfword bit0 is replaced by the half being accessed.
    assign sel_addr        = pick_mem ? mem_addr[ADDR_W-1:1] : if_addr[ADDR_W-1:1];
    assign addr_lsb_unused = if_addr[0] ^ mem_addr[0];

    assign cnt_load = (state == IDLE && grant) || (state == LO && half_last);

    sram_wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (3'(WAIT_CYCLES)),
        .last     (half_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            op_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lo_q      <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner     <= pick_mem ? OWN_MEM : OWN_IF;
                        op_wr     <= pick_mem && mem_wr;
                        addr_q    <= sel_addr;
                        wdata_q   <= mem_wdata;
                        SRAM_ADDR <= {sel_addr, 1'b0};
                        SRAM_WE_N <= !(pick_mem && mem_wr);
                        state     <= LO;
                    end
                end
                LO: begin
                    if (half_last) begin
                        if (!op_wr) begin
                            lo_q <= SRAM_DQ;
                        end
                        SRAM_ADDR <= {addr_q, 1'b1};
                        state     <= HI;
                    end
                end
                HI: begin
                    if (half_last) begin
                        if (!op_wr && owner == OWN_MEM) begin
                            mem_rdata <= {SRAM_DQ, lo_q};
                        end
                        if (!op_wr && owner == OWN_IF) begin
                            if_rdata <= {SRAM_DQ, lo_q};
                        end
                        SRAM_WE_N <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign drive_en  = op_wr && (state == LO || state == HI);
    assign half_data = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ   = drive_en ? half_data : 'z;

    assign if_freeze  = if_req  && !(state == DONE && owner == OWN_IF);
    assign mem_freeze = mem_req && !(state == DONE && owner == OWN_MEM);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized self-checking bench with SRAM model and transaction-level reference
module tb_sram_port_arbiter;

    localparam int W   = 1;
    localparam int LAT = 2 * (W + 1) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [17:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_freeze;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [17:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_freeze;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;

    int ntests = 0;
    int nfail  = 0;

    sram_port_arbiter #(.WAIT_CYCLES(W), .ADDR_W(18)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_freeze  (if_freeze),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_freeze (mem_freeze),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input int i);
        return 16'((i * 16'h1357) ^ 16'hA5A5);
    endfunction

    // SRAM model: a half commits once WE_N has been held low at one address for W+1 cycles.
    logic [15:0] sram_mem [0:255];
    bit          mem_ready = 1'b0;
    int          hold_n = 0;
    logic [17:0] hold_addr = '0;
    int          we_low_cnt = 0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) sram_mem[i] = pat(i);
            mem_ready = 1'b1;
        end
        if (!SRAM_WE_N) begin
            we_low_cnt = we_low_cnt + 1;
            if (hold_n != 0 && hold_addr == SRAM_ADDR) hold_n = hold_n + 1;
            else hold_n = 1;
            hold_addr = SRAM_ADDR;
            if (hold_n == W + 1) sram_mem[SRAM_ADDR[7:0]] = SRAM_DQ;
        end else begin
            hold_n = 0;
        end
    end

    assign SRAM_DQ = SRAM_WE_N ? sram_mem[SRAM_ADDR[7:0]] : 16'hzzzz;

    // Reference model state
    logic [15:0] ref_mem [0:255];
    logic [31:0] if_rdata_exp  = '0;
    logic [31:0] mem_rdata_exp = '0;
    bit          last_was_mem  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_mem_wins();
`ifdef ARB_ROUND_ROBIN_EN
        return !last_was_mem;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] ref_word(input logic [17:0] a);
        return {ref_mem[{a[7:1], 1'b1}], ref_mem[{a[7:1], 1'b0}]};
    endfunction

    function automatic int serve_mem(input bit wr, input logic [17:0] a, input logic [31:0] wd);
        last_was_mem = 1'b1;
        if (wr) begin
            ref_mem[{a[7:1], 1'b0}] = wd[15:0];
            ref_mem[{a[7:1], 1'b1}] = wd[31:16];
            return 2 * (W + 1);
        end
        mem_rdata_exp = ref_word(a);
        return 0;
    endfunction

    function automatic void serve_if(input logic [17:0] a);
        last_was_mem = 1'b0;
        if_rdata_exp = ref_word(a);
    endfunction

    task automatic run_txn(input bit use_if, input bit rd, input bit wr,
                           input logic [17:0] ia, input logic [17:0] ma, input logic [31:0] wd);
        bit use_mem = rd | wr;
        bit mem_first;
        bit if_pend, mem_pend;
        int if_exp_n = 0, mem_exp_n = 0, exp_we = 0, we_before;

        mem_first = use_mem && (!use_if || model_mem_wins());
        if (mem_first) begin
            exp_we    = serve_mem(wr, ma, wd);
            mem_exp_n = LAT;
            if (use_if) begin
                serve_if(ia);
                if_exp_n = 2 * LAT + 1;
            end
        end else begin
            if (use_if) begin
                serve_if(ia);
                if_exp_n = LAT;
            end
            if (use_mem) begin
                exp_we    = serve_mem(wr, ma, wd);
                mem_exp_n = use_if ? 2 * LAT + 1 : LAT;
            end
        end

        @(posedge clk);
        @(negedge clk);
        we_before = we_low_cnt;
        if_req    = use_if;
        if_addr   = ia;
        mem_rd    = rd;
        mem_wr    = wr;
        mem_addr  = ma;
        mem_wdata = wd;
        if_pend   = use_if;
        mem_pend  = use_mem;
        for (int n = 1; n <= 60 && (if_pend || mem_pend); n++) begin
            @(posedge clk);
            #1;
            if (if_pend && !if_freeze) begin
                check("if_latency", n, if_exp_n);
                check("if_rdata", if_rdata, if_rdata_exp);
                if_req  = 1'b0;
                if_pend = 1'b0;
            end
            if (mem_pend && !mem_freeze) begin
                check("mem_latency", n, mem_exp_n);
                check("mem_rdata", mem_rdata, mem_rdata_exp);
                mem_rd   = 1'b0;
                mem_wr   = 1'b0;
                mem_pend = 1'b0;
            end
        end
        check("if_timeout", 32'(if_pend), 0);
        check("mem_timeout", 32'(mem_pend), 0);
        if_req = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        check("we_low_cycles", we_low_cnt - we_before, exp_we);
        check("if_rdata_hold", if_rdata, if_rdata_exp);
        if (wr) begin
            check("sram_lo", sram_mem[{ma[7:1], 1'b0}], ref_mem[{ma[7:1], 1'b0}]);
            check("sram_hi", sram_mem[{ma[7:1], 1'b1}], ref_mem[{ma[7:1], 1'b1}]);
        end
    endtask

    initial begin
        logic [17:0] a;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

        repeat (3) @(posedge clk);
        #1;
        check("rst_we_n", SRAM_WE_N, 1);
        check("rst_addr", SRAM_ADDR, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_freeze", {if_freeze, mem_freeze}, 0);
        @(negedge clk);
        rst = 1'b0;

        run_txn(0, 0, 1, 18'h0, 18'h00010, 32'hDEADBEEF);
        check("t1_word_lo", sram_mem[8'h10], 32'h0000BEEF);
        check("t1_word_hi", sram_mem[8'h11], 32'h0000DEAD);
        run_txn(0, 1, 0, 18'h0, 18'h00010, 32'h0);
        check("t2_rdata", mem_rdata, 32'hDEADBEEF);
        run_txn(1, 0, 0, 18'h00021, 18'h0, 32'h0);
        run_txn(1, 1, 0, 18'h00030, 18'h00040, 32'h0);
        run_txn(0, 1, 0, 18'h0, 18'h00050, 32'h0);
        run_txn(1, 1, 0, 18'h00060, 18'h00070, 32'h0);
        run_txn(0, 1, 1, 18'h0, 18'h00081, 32'h12345678);

        for (int k = 0; k < 40; k++) begin
            int kind = $urandom_range(0, 4);
            logic [17:0] ia = 18'($urandom_range(0, 255));
            logic [17:0] ma = 18'($urandom_range(0, 255));
            logic [31:0] wd = $urandom;
            bit          r  = 1'($urandom_range(0, 1));
            case (kind)
                0: run_txn(1, 0, 0, ia, ma, wd);
                1: run_txn(0, 1, 0, ia, ma, wd);
                2: run_txn(0, 0, 1, ia, ma, wd);
                3: run_txn(0, 1, 1, ia, ma, wd);
                default: run_txn(1, r, !r, ia, ma, wd);
            endcase
        end

        // Reset during the high half of a write: only the low half lands.
        a = 18'h000A4;
        @(posedge clk);
        @(negedge clk);
        mem_wr    = 1'b1;
        mem_addr  = a;
        mem_wdata = 32'hCAFEF00D;
        ref_mem[8'hA4] = 16'hF00D;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("hi_we_n", SRAM_WE_N, 0);
        check("hi_addr", SRAM_ADDR, 18'h000A5);
        @(negedge clk);
        rst    = 1'b1;
        mem_wr = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_we_n", SRAM_WE_N, 1);
        check("rst_mid_addr", SRAM_ADDR, 0);
        check("rst_mid_freeze", mem_freeze, 0);
        check("rst_mid_mem_rdata", mem_rdata, 0);
        check("rst_mid_if_rdata", if_rdata, 0);
        @(negedge clk);
        rst           = 1'b0;
        mem_rdata_exp = '0;
        if_rdata_exp  = '0;
        last_was_mem  = 1'b0;
        check("rst_mid_lo_written", sram_mem[8'hA4], ref_mem[8'hA4]);
        check("rst_mid_hi_kept", sram_mem[8'hA5], ref_mem[8'hA5]);
        run_txn(1, 0, 0, a, 18'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
